// File: rtl/tdm_burst_packer.sv
// rtl/tdm_burst_packer.sv - de-interleaves a TDM sample stream into per-lane FIFOs and emits fixed-length bursts
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-low reset
//   din, din_valid  interleaved sample stream (lane 0, lane 1, ...)
//   slot_sync       with din_valid, forces the current sample into lane 0
//   dout, dout_lane burst data (head of the selected lane FIFO) and its lane ID
//   dout_valid/_ready/_last  burst handshake, last marks the final beat
//   overflow        sticky per-lane drop flags, cleared only by reset
module tdm_burst_packer #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_LANES  = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int BURST_LEN  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        din,
  input  logic                         din_valid,
  input  logic                         slot_sync,
  output logic [DATA_WIDTH-1:0]        dout,
  output logic [$clog2(NUM_LANES)-1:0] dout_lane,
  output logic                         dout_valid,
  input  logic                         dout_ready,
  output logic                         dout_last,
  output logic [NUM_LANES-1:0]         overflow
);

  localparam int LW = $clog2(NUM_LANES);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(BURST_LEN);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t                 state_q, state_d;
  logic [LW-1:0]          slot_q, slot_d;
  logic [LW-1:0]          lane_q, lane_d;
  logic [LW-1:0]          last_lane_q, last_lane_d;
  logic [BW-1:0]          beat_q, beat_d;
  logic                   last_q, last_d;
  logic [NUM_LANES-1:0]   ovf_q, ovf_d;
  logic [PW-1:0]          wptr_q [NUM_LANES];
  logic [PW-1:0]          wptr_d [NUM_LANES];
  logic [PW-1:0]          rptr_q [NUM_LANES];
  logic [PW-1:0]          rptr_d [NUM_LANES];
  logic [CW-1:0]          cnt_q  [NUM_LANES];
  logic [CW-1:0]          cnt_d  [NUM_LANES];
  logic [DATA_WIDTH-1:0]  mem_q  [NUM_LANES][FIFO_DEPTH];

  logic [LW-1:0]          wr_lane;
  logic [NUM_LANES-1:0]   full;
  logic [NUM_LANES-1:0]   wr_en;
  logic [NUM_LANES-1:0]   rd_en;
  logic [LW-1:0]          cand;
  logic                   found;

  // Slot counter and lane FIFO bookkeeping. Lane counts are a power of two,
  // so the slot increment wraps on its own. Full uses the registered count,
  // so a same-cycle read never makes room for the incoming sample.
  always_comb begin
    wr_lane = slot_sync ? '0 : slot_q;
    slot_d  = slot_q;
    if (din_valid) begin
      slot_d = wr_lane + LW'(1);
    end
    for (int l = 0; l < NUM_LANES; l++) begin
      full[l]   = (cnt_q[l] == CW'(FIFO_DEPTH));
      wr_en[l]  = din_valid && (wr_lane == LW'(l)) && !full[l];
      ovf_d[l]  = ovf_q[l] | (din_valid && (wr_lane == LW'(l)) && full[l]);
      rd_en[l]  = (state_q == S_BURST) && dout_ready && (lane_q == LW'(l));
      wptr_d[l] = wptr_q[l] + PW'(wr_en[l]);
      rptr_d[l] = rptr_q[l] + PW'(rd_en[l]);
      cnt_d[l]  = cnt_q[l] + CW'(wr_en[l]) - CW'(rd_en[l]);
    end
  end

  // Output FSM: round-robin search starts just after the last served lane.
  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    beat_d      = beat_q;
    last_lane_d = last_lane_q;
    found       = 1'b0;
    cand        = '0;
    case (state_q)
      S_IDLE: begin
        for (int i = 0; i < NUM_LANES; i++) begin
          cand = last_lane_q + LW'(1) + LW'(i);
          if (!found && (cnt_q[cand] >= CW'(BURST_LEN))) begin
            found  = 1'b1;
            lane_d = cand;
          end
        end
        if (found) begin
          state_d = S_BURST;
          beat_d  = '0;
        end
      end
      S_BURST: begin
        if (dout_ready) begin
          if (beat_q == BW'(BURST_LEN - 1)) begin
            state_d     = S_IDLE;
            last_lane_d = lane_q;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    last_d = (state_d == S_BURST) && (beat_d == BW'(BURST_LEN - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      slot_q      <= '0;
      lane_q      <= '0;
      last_lane_q <= LW'(NUM_LANES - 1);
      beat_q      <= '0;
      last_q      <= 1'b0;
      ovf_q       <= '0;
      for (int l = 0; l < NUM_LANES; l++) begin
        wptr_q[l] <= '0;
        rptr_q[l] <= '0;
        cnt_q[l]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      lane_q      <= lane_d;
      last_lane_q <= last_lane_d;
      beat_q      <= beat_d;
      last_q      <= last_d;
      ovf_q       <= ovf_d;
      for (int l = 0; l < NUM_LANES; l++) begin
        wptr_q[l] <= wptr_d[l];
        rptr_q[l] <= rptr_d[l];
        cnt_q[l]  <= cnt_d[l];
      end
    end
  end

  // Sample storage carries no reset: pointers and counts define validity.
  always_ff @(posedge clk) begin
    for (int l = 0; l < NUM_LANES; l++) begin
      if (wr_en[l]) begin
        mem_q[l][wptr_q[l]] <= din;
      end
    end
  end

  // First-word-fall-through read; forced to zero outside a burst.
  assign dout       = (state_q == S_BURST) ? mem_q[lane_q][rptr_q[lane_q]] : '0;
  assign dout_lane  = lane_q;
  assign dout_valid = (state_q == S_BURST);
  assign dout_last  = last_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_tdm_burst_packer.sv
// tb/tb_tdm_burst_packer.sv - scoreboard bench for tdm_burst_packer
module tb_tdm_burst_packer;

  localparam int NL = 2;
  localparam int DEPTH = 16;
  localparam int BL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] din = '0;
  logic        din_valid = 1'b0;
  logic        slot_sync = 1'b0;
  logic        dout_ready = 1'b0;
  logic [15:0] dout;
  logic [0:0]  dout_lane;
  logic        dout_valid;
  logic        dout_last;
  logic [1:0]  overflow;

  tdm_burst_packer #(
    .DATA_WIDTH(16), .NUM_LANES(NL), .FIFO_DEPTH(DEPTH), .BURST_LEN(BL)
  ) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .slot_sync(slot_sync),
    .dout(dout), .dout_lane(dout_lane), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_last(dout_last), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: contents of each lane FIFO as the specification implies.
  logic [15:0] exp_q [NL][$];
  int          slot = 0;
  logic [1:0]  exp_ovf = '0;
  logic [1:0]  exp_ovf_next = '0;
  bit          pend_wr = 1'b0;
  int          pend_lane = 0;

  // Monitor state.
  bit in_burst = 1'b0;
  int beat = 0;
  int burst_lane = 0;
  int last_lane = NL - 1;
  bit pred_ok = 1'b0;
  int pred_lane = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endfunction

  // Monitor: samples mid-cycle, pops the scoreboard on every accepted beat.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_dout", dout, 0);
      chk("rst_valid", dout_valid, 0);
      chk("rst_last", dout_last, 0);
      chk("rst_lane", dout_lane, 0);
      chk("rst_ovf", overflow, 0);
      in_burst = 1'b0;
      beat = 0;
      last_lane = NL - 1;
      pred_ok = 1'b0;
    end else begin
      chk("overflow", overflow, exp_ovf);
      if (dout_valid) begin
        if (!in_burst) begin
          chk("arb_expected", pred_ok, 1);
          chk("arb_lane", dout_lane, pred_lane);
          in_burst = 1'b1;
          burst_lane = dout_lane;
          beat = 0;
        end
        chk("burst_lane", dout_lane, burst_lane);
        chk("dout_last", dout_last, (beat == BL - 1));
        checks++;
        if (exp_q[burst_lane].size() == 0) begin
          errors++;
          $display("FAIL dout_unexpected actual=0x%0h required=none lane=%0d", dout, burst_lane);
        end else begin
          if (dout !== exp_q[burst_lane][0]) begin
            errors++;
            $display("FAIL dout actual=0x%0h required=0x%0h lane=%0d beat=%0d",
                     dout, exp_q[burst_lane][0], burst_lane, beat);
          end
          if (dout_ready) void'(exp_q[burst_lane].pop_front());
        end
        if (dout_ready) begin
          beat++;
          if (beat == BL) begin
            in_burst = 1'b0;
            last_lane = burst_lane;
          end
        end
        pred_ok = 1'b0;
      end else begin
        chk("valid_drop", in_burst, 0);
        chk("idle_gap", pred_ok, 0);
        pred_ok = 1'b0;
        for (int i = 0; i < NL; i++) begin
          int l;
          int occ;
          l = (last_lane + 1 + i) % NL;
          occ = exp_q[l].size() - ((pend_wr && pend_lane == l) ? 1 : 0);
          if (!pred_ok && occ >= BL) begin
            pred_ok = 1'b1;
            pred_lane = l;
          end
        end
      end
    end
  end

  // One cycle of stimulus: drive now, then step past the next rising edge.
  task automatic cyc(input bit v, input bit s, input logic [15:0] d, input bit r);
    din_valid = v;
    slot_sync = s;
    din = d;
    dout_ready = r;
    pend_wr = 1'b0;
    if (v) begin
      int lane;
      lane = s ? 0 : slot;
      slot = (lane + 1) % NL;
      if (exp_q[lane].size() >= DEPTH) begin
        exp_ovf_next[lane] = 1'b1;
      end else begin
        exp_q[lane].push_back(d);
        pend_wr = 1'b1;
        pend_lane = lane;
      end
    end
    @(posedge clk);
    #2;
    exp_ovf = exp_ovf_next;
    pend_wr = 1'b0;
    din_valid = 1'b0;
    slot_sync = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    din_valid = 1'b0;
    slot_sync = 1'b0;
    dout_ready = 1'b0;
    for (int l = 0; l < NL; l++) exp_q[l].delete();
    slot = 0;
    exp_ovf = '0;
    exp_ovf_next = '0;
    pend_wr = 1'b0;
    #1;
    chk("async_rst_valid", dout_valid, 0);
    chk("async_rst_dout", dout, 0);
    chk("async_rst_last", dout_last, 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q[0].size() >= BL || exp_q[1].size() >= BL || dout_valid) && n < 400) begin
      cyc(1'b0, 1'b0, 16'h0, 1'b1);
      n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL %s_drain actual=timeout required=drained q0=%0d q1=%0d", name,
               exp_q[0].size(), exp_q[1].size());
    end
  endtask

  task automatic wait_beat(input string name, input int target);
    int n;
    n = 0;
    while (!(dout_valid && in_burst && beat == target) && n < 40) begin
      cyc(1'b0, 1'b0, 16'h0, 1'b1);
      n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL %s_wait actual=timeout required=beat%0d", name, target);
    end
  endtask

  initial begin
    do_reset();

    // Basic burst.
    for (int i = 1; i <= 8; i++) cyc(1'b1, i == 1, 16'(i), 1'b1);
    drain("basic");
    chk("basic_ovf", overflow, 2'b00);

    // Resync: second sample re-marked as lane 0 while slot is 1.
    cyc(1'b1, 1'b1, 16'h0A00, 1'b1);
    cyc(1'b1, 1'b1, 16'h0A01, 1'b1);
    for (int i = 2; i < 10; i++) cyc(1'b1, 1'b0, 16'h0A00 + 16'(i), 1'b1);
    drain("resync");

    // Backpressure at beat 2.
    do_reset();
    for (int i = 1; i <= 8; i++) cyc(1'b1, i == 1, 16'h0100 + 16'(i), 1'b1);
    wait_beat("bp", 2);
    repeat (5) cyc(1'b0, 1'b0, 16'h0, 1'b0);
    drain("bp");

    // Overflow: no reads while 40 samples arrive.
    do_reset();
    for (int i = 0; i < 40; i++) cyc(1'b1, i == 0, 16'h2000 + 16'(i), 1'b0);
    chk("ovf_both", overflow, 2'b11);
    drain("ovf");
    chk("ovf_sticky", overflow, 2'b11);

    // Reset mid-burst during beat 1, then the basic sequence again.
    do_reset();
    for (int i = 1; i <= 8; i++) cyc(1'b1, i == 1, 16'h0300 + 16'(i), 1'b1);
    wait_beat("midrst", 1);
    do_reset();
    for (int i = 1; i <= 8; i++) cyc(1'b1, i == 1, 16'(i), 1'b1);
    drain("postrst");

    // Round-robin under saturating input.
    do_reset();
    for (int i = 0; i < 300; i++) cyc(1'b1, i == 0, 16'($urandom), 1'b1);
    drain("rr");

    // Randomized traffic at several load and backpressure levels.
    do_reset();
    for (int seg = 0; seg < 6; seg++) begin
      int vr;
      int rr;
      vr = (seg % 3 == 0) ? 30 : ((seg % 3 == 1) ? 70 : 100);
      rr = (seg < 3) ? 90 : 40;
      for (int i = 0; i < 500; i++) begin
        cyc(($urandom % 100) < vr, ($urandom % 16) == 0, 16'($urandom), ($urandom % 100) < rr);
      end
    end
    drain("random");

    repeat (3) cyc(1'b0, 1'b0, 16'h0, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
